// File: rtl/wb_sram16.sv
// wb_sram16: Wishbone classic slave serving 32-bit single-beat cycles from an
// external 16-bit asynchronous SRAM. Each 32-bit access is split into two timed
// half-word accesses (low half first, then high half).
//
// Optional feature (compile-time macro):
//   WB_SRAM_LANE_SKIP_EN - write halves with no selected byte are skipped entirely.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   wb_adr_i [AWIDTH:2]   word address
//   wb_dat_i / wb_dat_o   32-bit write / read data
//   wb_sel_i [3:0]        byte selects
//   wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_stall_o
//   sram_adr [AWIDTH-1:0] half-word address
//   sram_dq  [15:0]       bidirectional data, driven only during write phases
//   sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  active-low strobes
module wb_sram16 #(
    parameter int unsigned AWIDTH = 20,
    parameter int unsigned WAIT   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AWIDTH:2]   wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic              wb_ack_o,
    output logic              wb_stall_o,
    output logic [AWIDTH-1:0] sram_adr,
    inout  wire  [15:0]       sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam int unsigned CW = 4;
    localparam int unsigned WA = AWIDTH - 1;

`ifdef WB_SRAM_LANE_SKIP_EN
    localparam bit LANE_SKIP = 1'b1;
`else
    localparam bit LANE_SKIP = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_TURN, S_LO, S_HI, S_ACK} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WA-1:0]   adr_q, adr_d;
    logic            we_q, we_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     wdat_q, wdat_d;
    logic            abort_q, abort_d;
    logic            rd_last_q, rd_last_d;
    logic [31:0]     dat_o_q, dat_o_d;
    logic            ack_q, ack_d;
    logic            stall_q, stall_d;
    logic [WA:0]     sram_adr_q, sram_adr_d;
    logic            ce_n_q, ce_n_d;
    logic            oe_n_q, oe_n_d;
    logic            we_n_q, we_n_d;
    logic            ub_n_q, ub_n_d;
    logic            lb_n_q, lb_n_d;
    logic            dq_oe_q, dq_oe_d;
    logic [15:0]     dq_out_q, dq_out_d;

    logic            in_phase;
    logic            hi_half;
    logic [1:0]      lanes;

    // A half needs an SRAM phase unless lane skipping drops an unselected write half.
    function automatic logic half_en(input logic we, input logic [1:0] sel2);
        return !LANE_SKIP || !we || (|sel2);
    endfunction

    // Next-state, capture and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        we_d      = we_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        abort_d   = abort_q;
        rd_last_d = rd_last_q;
        dat_o_d   = dat_o_q;

        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d   = wb_adr_i;
                    we_d    = wb_we_i;
                    sel_d   = wb_sel_i;
                    wdat_d  = wb_dat_i;
                    abort_d = 1'b0;
                    cnt_d   = '0;
                    if (!wb_we_i)
                        state_d = S_LO;
                    else if (!half_en(1'b1, wb_sel_i[1:0]) && !half_en(1'b1, wb_sel_i[3:2]))
                        state_d = S_ACK;
                    else if (rd_last_q)
                        state_d = S_TURN;
                    else
                        state_d = half_en(1'b1, wb_sel_i[1:0]) ? S_LO : S_HI;
                end
            end
            S_TURN: begin
                cnt_d = '0;
                if (!wb_cyc_i)
                    state_d = S_IDLE;
                else
                    state_d = half_en(we_q, sel_q[1:0]) ? S_LO : S_HI;
            end
            S_LO, S_HI: begin
                // An abort is remembered but the phase always runs to completion.
                abort_d = abort_q | ~wb_cyc_i;
                if (cnt_q == CW'(WAIT)) begin
                    cnt_d = '0;
                    if (!we_q) begin
                        if (state_q == S_HI) dat_o_d[31:16] = sram_dq;
                        else                 dat_o_d[15:0]  = sram_dq;
                    end
                    if (abort_q || !wb_cyc_i)
                        state_d = S_IDLE;
                    else if (state_q == S_LO && half_en(we_q, sel_q[3:2]))
                        state_d = S_HI;
                    else
                        state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Pin values for the cycle being entered.
        in_phase = (state_d == S_LO) || (state_d == S_HI);
        hi_half  = (state_d == S_HI);
        lanes    = hi_half ? sel_d[3:2] : sel_d[1:0];

        ack_d    = (state_d == S_ACK);
        stall_d  = (state_d == S_TURN) || in_phase;
        ce_n_d   = !in_phase;
        oe_n_d   = !(in_phase && !we_d);
        we_n_d   = !(in_phase && we_d && (cnt_d != '0));
        dq_oe_d  = in_phase && we_d;
        dq_out_d = hi_half ? wdat_d[31:16] : wdat_d[15:0];
        ub_n_d   = !in_phase || (we_d && !lanes[1]);
        lb_n_d   = !in_phase || (we_d && !lanes[0]);
        // Address only moves at the first cycle of a phase.
        sram_adr_d = (in_phase && cnt_d == '0) ? {adr_d, hi_half} : sram_adr_q;
        if (in_phase) rd_last_d = !we_d;
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            adr_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            wdat_q     <= '0;
            abort_q    <= 1'b0;
            rd_last_q  <= 1'b0;
            dat_o_q    <= '0;
            ack_q      <= 1'b0;
            stall_q    <= 1'b0;
            sram_adr_q <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            ub_n_q     <= 1'b1;
            lb_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            wdat_q     <= wdat_d;
            abort_q    <= abort_d;
            rd_last_q  <= rd_last_d;
            dat_o_q    <= dat_o_d;
            ack_q      <= ack_d;
            stall_q    <= stall_d;
            sram_adr_q <= sram_adr_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            ub_n_q     <= ub_n_d;
            lb_n_q     <= lb_n_d;
            dq_oe_q    <= dq_oe_d;
            dq_out_q   <= dq_out_d;
        end
    end

    assign sram_dq    = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign wb_dat_o   = dat_o_q;
    assign wb_ack_o   = ack_q;
    assign wb_stall_o = stall_q;
    assign sram_adr   = sram_adr_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_wb_sram16.sv
// Testbench for wb_sram16: byte-maskable async SRAM model with strobe-timing
// checks, word/byte-lane reference memory, directed scenarios plus random traffic.
module tb_wb_sram16;

    localparam int unsigned AW = 12;
    localparam int unsigned WT = 2;
    localparam int unsigned NW = 1 << (AW - 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [AW:2]   wb_adr;
    logic [31:0]   wb_dat_i;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel;
    logic          wb_we, wb_cyc, wb_stb;
    logic          wb_ack, wb_stall;
    logic [AW-1:0] sram_adr;
    wire  [15:0]   sram_dq;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    logic [15:0]   smem [0:(1<<AW)-1];
    logic [31:0]   ref_mem [0:NW-1];
    logic          mem_clr;
    bit            last_rd;
    int            tests = 0;
    int            fails = 0;
    int            viol = 0;
    logic          prev_ce_n = 1'b1, prev_oe_n = 1'b1, prev_we_n = 1'b1;
    logic [AW-1:0] prev_adr = '0;

    always #5 clk = ~clk;

    wb_sram16 #(.AWIDTH(AW), .WAIT(WT)) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
        .wb_ack_o(wb_ack), .wb_stall_o(wb_stall),
        .sram_adr(sram_adr), .sram_dq(sram_dq),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    // SRAM model drives data while output-enabled and not writing.
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? smem[sram_adr] : 16'hzzzz;

    // Byte-masked writes plus we_n setup / hold / bus-turnaround checks.
    always @(negedge clk) begin
        int v;
        v = 0;
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) smem[i] <= 16'h0000;
        end else if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) smem[sram_adr][7:0]  <= sram_dq[7:0];
            if (!sram_ub_n) smem[sram_adr][15:8] <= sram_dq[15:8];
        end
        if (!sram_we_n && (sram_ce_n || !sram_oe_n)) v++;
        if (!sram_we_n && prev_we_n && (prev_ce_n || prev_adr != sram_adr)) v++;
        if (!sram_we_n && !prev_we_n && prev_adr != sram_adr) v++;
        if (!sram_ce_n && sram_oe_n && !prev_oe_n) v++;
        viol      <= viol + v;
        prev_ce_n <= sram_ce_n;
        prev_oe_n <= sram_oe_n;
        prev_we_n <= sram_we_n;
        prev_adr  <= sram_adr;
    end

    // Expected stb-to-ack cycles from the half-phase count and turnaround rule.
    function automatic int exp_lat(input logic we, input logic [3:0] sel);
        int ph;
        ph = 2;
`ifdef WB_SRAM_LANE_SKIP_EN
        if (we) ph = int'(|sel[1:0]) + int'(|sel[3:2]);
`endif
        return ph * (int'(WT) + 1) + 1 + ((we && last_rd && ph > 0) ? 1 : 0);
    endfunction

    // One Wibshone cycle: stb for one clock, wait (bounded) for ack.
    task automatic do_cycle(input logic [AW-2:0] a, input logic we, input logic [3:0] sel,
                            input logic [31:0] d, input bit keep,
                            output logic [31:0] rd, output int lat, output bit stall_ok);
        int n;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = a; wb_we = we; wb_sel = sel; wb_dat_i = d;
        n = 0; lat = -1; stall_ok = 1'b1; rd = '0;
        while (n < 40 && lat < 0) begin
            @(negedge clk);
            n++;
            wb_stb = 1'b0;
            if (wb_ack) begin
                lat = n; rd = wb_dat_o;
                if (wb_stall) stall_ok = 1'b0;
            end else if (!wb_stall) begin
                stall_ok = 1'b0;
            end
        end
        if (!keep) wb_cyc = 1'b0;
    endtask

    // Bus operation with reference-memory bookkeeping.
    task automatic op(input logic [AW-2:0] a, input logic we, input logic [3:0] sel,
                      input logic [31:0] d, input bit keep,
                      output logic [31:0] rd, output logic [31:0] erd,
                      output int lat, output int elat, output bit stall_ok);
        elat = exp_lat(we, sel);
        erd  = ref_mem[a];
        do_cycle(a, we, sel, d, keep, rd, lat, stall_ok);
        if (we) begin
            for (int i = 0; i < 4; i++) if (sel[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
            if (elat > 1) last_rd = 1'b0;
        end else begin
            last_rd = 1'b1;
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({wb_ack, wb_stall, wb_dat_o} !== 34'h0) begin
            fails++; $display("FAIL reset_bus: ack/stall/dat_o=%0h expected 0", {wb_ack, wb_stall, wb_dat_o});
        end
        tests++;
        if (sram_adr !== '0) begin
            fails++; $display("FAIL reset_adr: got %0h expected 0", sram_adr);
        end
        tests++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
            fails++; $display("FAIL reset_strobes: got %b expected 11111",
                              {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd, erd; int lat, elat; bit sok;
        op(11'h004, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, rd, erd, lat, elat, sok);
        tests++;
        if (lat != 7 || !sok) begin
            fails++; $display("FAIL basic_wr_lat: got %0d stall_ok=%0d expected 7 stall_ok=1", lat, sok);
        end
        op(11'h004, 1'b0, 4'hF, 32'h0, 1'b0, rd, erd, lat, elat, sok);
        tests++;
        if (lat != 7 || !sok) begin
            fails++; $display("FAIL basic_rd_lat: got %0d stall_ok=%0d expected 7 stall_ok=1", lat, sok);
        end
        tests++;
        if (rd !== 32'hDEADBEEF) begin
            fails++; $display("FAIL basic_rd_data: got %08h expected deadbeef", rd);
        end
        tests++;
        if (smem[8] !== 16'hBEEF || smem[9] !== 16'hDEAD) begin
            fails++; $display("FAIL basic_sram: got %04h/%04h expected beef/dead", smem[8], smem[9]);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, erd; int lat, elat; bit sok;
        op(11'h008, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b0, rd, erd, lat, elat, sok);
        tests++;
        if (lat != elat) begin
            fails++; $display("FAIL lanes_preload_lat: got %0d expected %0d", lat, elat);
        end
        op(11'h008, 1'b1, 4'b0101, 32'h12345678, 1'b0, rd, erd, lat, elat, sok);
        tests++;
        if (lat != elat) begin
            fails++; $display("FAIL lanes_wr_lat: got %0d expected %0d", lat, elat);
        end
        op(11'h008, 1'b0, 4'hF, 32'h0, 1'b0, rd, erd, lat, elat, sok);
        tests++;
        if (rd !== 32'hFF34FF78 || rd !== erd) begin
            fails++; $display("FAIL lanes_rd_data: got %08h expected ff34ff78", rd);
        end
    endtask

    task automatic test_line_fill();
        logic [31:0] rd, erd; int lat, elat; bit sok;
        for (int i = 0; i < 4; i++)
            op(11'(i), 1'b1, 4'hF, $urandom, 1'b0, rd, erd, lat, elat, sok);
        for (int i = 0; i < 4; i++) begin
            op(11'(i), 1'b0, 4'hF, 32'h0, (i != 3), rd, erd, lat, elat, sok);
            tests++;
            if (rd !== erd || lat != elat || sram_ce_n !== 1'b1) begin
                fails++; $display("FAIL fill_beat%0d: data %08h lat %0d ce_n %b expected %08h lat %0d ce_n 1",
                                  i, rd, lat, sram_ce_n, erd, elat);
            end
        end
    endtask

    task automatic test_turnaround();
        logic [31:0] rd, erd; int lat, elat; bit sok;
        op(11'h005, 1'b0, 4'hF, 32'h0, 1'b0, rd, erd, lat, elat, sok);
        op(11'h005, 1'b1, 4'hF, 32'hA5A5_5A5A, 1'b0, rd, erd, lat, elat, sok);
        tests++;
        if (lat != 8 || lat != elat) begin
            fails++; $display("FAIL turn_wr_lat: got %0d expected 8", lat);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, erd; int lat, elat; bit sok;
        bit ack_seen; logic ce3, ce4, st4;
        ack_seen = 1'b0; ce3 = 1'b1; ce4 = 1'b0; st4 = 1'b1;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 11'h003; wb_sel = 4'hF;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            wb_stb = 1'b0;
            if (wb_ack) ack_seen = 1'b1;
            if (n == 3) ce3 = sram_ce_n;
            if (n == 4) begin ce4 = sram_ce_n; st4 = wb_stall; end
            if (n == 2) wb_cyc = 1'b0;
        end
        last_rd = 1'b1;
        tests++;
        if (ack_seen || ce3 !== 1'b0 || ce4 !== 1'b1 || st4 !== 1'b0) begin
            fails++; $display("FAIL abort_shape: ack=%0d ce3=%b ce4=%b stall4=%b expected 0/0/1/0",
                              ack_seen, ce3, ce4, st4);
        end
        op(11'h003, 1'b0, 4'hF, 32'h0, 1'b0, rd, erd, lat, elat, sok);
        tests++;
        if (rd !== erd || lat != elat) begin
            fails++; $display("FAIL abort_next: data %08h lat %0d expected %08h lat %0d", rd, lat, erd, elat);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd, erd; int lat, elat; bit sok; int bad;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 11'd20; wb_sel = 4'hF;
        wb_dat_i = 32'hCAFE_F00D;
        repeat (5) begin
            @(negedge clk);
            wb_stb = 1'b0;
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, wb_stall, wb_ack} !== 7'b1111100) begin
            fails++; $display("FAIL rst_mid_pins: got %b expected 1111100",
                              {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, wb_stall, wb_ack});
        end
        wb_cyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_rd = 1'b0;
        bad = 0;
        for (int i = 0; i < int'(NW); i++)
            if (i != 20 && ref_mem[i] !== {smem[2*i+1], smem[2*i]}) bad++;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL rst_mid_collateral: %0d words differ expected 0", bad);
        end
        ref_mem[20] = {smem[41], smem[40]};
        op(11'd20, 1'b1, 4'hF, 32'h0BAD_CAFE, 1'b0, rd, erd, lat, elat, sok);
        op(11'd20, 1'b0, 4'hF, 32'h0, 1'b0, rd, erd, lat, elat, sok);
        tests++;
        if (rd !== 32'h0BAD_CAFE || lat != elat) begin
            fails++; $display("FAIL rst_mid_recover: data %08h lat %0d expected 0badcafe lat %0d", rd, lat, elat);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd; int lat, elat; bit sok;
        logic we; logic [3:0] sel; logic [AW-2:0] a;
        for (int k = 0; k < 40; k++) begin
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom);
            a   = 11'($urandom_range(0, 63));
            op(a, we, sel, $urandom, 1'($urandom_range(0, 1)), rd, erd, lat, elat, sok);
            tests++;
            if (lat != elat || !sok || (!we && rd !== erd)) begin
                fails++; $display("FAIL random%0d: we=%0d a=%0d sel=%h data %08h lat %0d stall_ok %0d expected %08h lat %0d",
                                  k, we, a, sel, rd, lat, sok, erd, elat);
            end
        end
        @(negedge clk);
        wb_cyc = 1'b0;
    endtask

    task automatic test_final();
        int bad;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int i = 0; i < int'(NW); i++)
            if (ref_mem[i] !== {smem[2*i+1], smem[2*i]}) bad++;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL final_memory: %0d words differ expected 0", bad);
        end
        tests++;
        if (viol != 0) begin
            fails++; $display("FAIL sram_timing: %0d violations expected 0", viol);
        end
    endtask

    initial begin
        rst = 1'b1; mem_clr = 1'b1; last_rd = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_sel = 4'h0; wb_adr = '0; wb_dat_i = '0;
        for (int i = 0; i < int'(NW); i++) ref_mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        test_reset();
        rst = 1'b0;
        test_basic();
        test_byte_lanes();
        test_line_fill();
        test_turnaround();
        test_abort();
        test_reset_mid_write();
        test_random();
        test_final();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
